food_ctrl: RTL and testbench

FOOD_CTRL -- requirements
Module: food_ctrl

---
 rtl/food_ctrl.sv | 152 +++++++++++++++
 tb/tb_food_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_ctrl.sv
// Food placement controller: draws LFSR candidates, checks them against the snake body
// store, and commits a free cell on the next frame tick. Optional macro: FOOD_RETRY_CAP_EN.
module food_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       eat,
   output logic       occ_req,
   output logic [4:0] occ_h,
   output logic [4:0] occ_v,
   input  logic       occ_ack,
   input  logic       occ_hit,
   output logic [4:0] food_h,
   output logic [4:0] food_v,
   output logic       food_valid,
`ifdef FOOD_RETRY_CAP_EN
   output logic       food_fail,
`endif
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, DRAW, QUERY, ARM, COMMIT} state_t;

   state_t     state_q, state_d;
   logic [9:0] lfsr_q, lfsr_d;
   logic       occ_req_q, occ_req_d;
   logic [4:0] occ_h_q, occ_h_d;
   logic [4:0] occ_v_q, occ_v_d;
   logic [4:0] food_h_q, food_h_d;
   logic [4:0] food_v_q, food_v_d;
   logic       food_valid_q, food_valid_d;
   logic       busy_q, busy_d;
   logic [4:0] cand_h, cand_v;
`ifdef FOOD_RETRY_CAP_EN
   logic [4:0] retry_q, retry_d;
   logic       fail_q, fail_d;
`endif

   // Rows 24..31 fold down onto 16..23 so every candidate lands on the 32x24 grid.
   assign cand_h = lfsr_q[4:0];
   assign cand_v = (lfsr_q[9:5] < 5'd24) ? lfsr_q[9:5] : (lfsr_q[9:5] - 5'd8);

   always_comb begin
      lfsr_d       = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      state_d      = state_q;
      occ_req_d    = occ_req_q;
      occ_h_d      = occ_h_q;
      occ_v_d      = occ_v_q;
      food_h_d     = food_h_q;
      food_v_d     = food_v_q;
      food_valid_d = food_valid_q;
`ifdef FOOD_RETRY_CAP_EN
      retry_d      = retry_q;
      fail_d       = fail_q;
`endif
      case (state_q)
         IDLE: begin
            if (eat) begin
               state_d      = DRAW;
               food_valid_d = 1'b0;
`ifdef FOOD_RETRY_CAP_EN
               retry_d      = 5'd0;
               fail_d       = 1'b0;
`endif
            end
         end
         DRAW: begin
            occ_h_d   = cand_h;
            occ_v_d   = cand_v;
            occ_req_d = 1'b1;
            state_d   = QUERY;
         end
         QUERY: begin
            if (occ_ack) begin
               occ_req_d = 1'b0;
               if (occ_hit) begin
`ifdef FOOD_RETRY_CAP_EN
                  retry_d = retry_q + 5'd1;
                  if (retry_q == 5'd31) begin
                     state_d      = IDLE;
                     food_valid_d = 1'b0;
                     fail_d       = 1'b1;
                  end else begin
                     state_d = DRAW;
                  end
`else
                  state_d = DRAW;
`endif
               end else begin
                  state_d = ARM;
               end
            end
         end
         ARM: begin
            // Food registers load on the transition so the cell shows one clk after the tick.
            if (frame_tick) begin
               state_d      = COMMIT;
               food_h_d     = occ_h_q;
               food_v_d     = occ_v_q;
               food_valid_d = 1'b1;
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = DRAW;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= DRAW;
         lfsr_q       <= 10'h2A5;
         occ_req_q    <= 1'b0;
         occ_h_q      <= 5'd0;
         occ_v_q      <= 5'd0;
         food_h_q     <= 5'd0;
         food_v_q     <= 5'd0;
         food_valid_q <= 1'b0;
         busy_q       <= 1'b1;
`ifdef FOOD_RETRY_CAP_EN
         retry_q      <= 5'd0;
         fail_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         occ_req_q    <= occ_req_d;
         occ_h_q      <= occ_h_d;
         occ_v_q      <= occ_v_d;
         food_h_q     <= food_h_d;
         food_v_q     <= food_v_d;
         food_valid_q <= food_valid_d;
         busy_q       <= busy_d;
`ifdef FOOD_RETRY_CAP_EN
         retry_q      <= retry_d;
         fail_q       <= fail_d;
`endif
      end
   end

   assign occ_req    = occ_req_q;
   assign occ_h      = occ_h_q;
   assign occ_v      = occ_v_q;
   assign food_h     = food_h_q;
   assign food_v     = food_v_q;
   assign food_valid = food_valid_q;
   assign busy       = busy_q;
`ifdef FOOD_RETRY_CAP_EN
   assign food_fail  = fail_q;
`endif

endmodule

// File: tb/tb_food_ctrl.sv
// Scoreboard bench for food_ctrl: the driver predicts candidates and commits from a
// free-running reference LFSR sequence; a monitor pops and compares on DUT outputs.
`timescale 1ns/1ps
module tb_food_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1, frame_tick = 1'b0, eat = 1'b0, occ_ack = 1'b0, occ_hit = 1'b0;
   logic       occ_req, food_valid, busy;
   logic [4:0] occ_h, occ_v, food_h, food_v;
`ifdef FOOD_RETRY_CAP_EN
   logic       food_fail;
`endif

   always #5 clk = ~clk;

   food_ctrl dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .eat(eat),
      .occ_req(occ_req), .occ_h(occ_h), .occ_v(occ_v),
      .occ_ack(occ_ack), .occ_hit(occ_hit),
      .food_h(food_h), .food_v(food_v), .food_valid(food_valid),
`ifdef FOOD_RETRY_CAP_EN
      .food_fail(food_fail),
`endif
      .busy(busy)
   );

   typedef struct { logic [9:0] hv; int at; } food_t;

   int         checks = 0, failures = 0;
   int         cyc = 0;
   int         streak = 0;
   bit         capped;
   logic [9:0] m_lfsr = 10'h2A5;
   logic [9:0] m_cand = 10'd0;
   logic [9:0] cand_q[$];
   food_t      food_q[$];
   logic [9:0] got_hv, prev_hv = 10'd0;
   food_t      exp_food;
   logic       prev_req = 1'b0, prev_valid = 1'b0;

   // Feedback taps from x^10 + x^7 + 1.
   localparam logic [9:0] TAPS = 10'b10_0100_0000;

   function automatic logic [9:0] lfsr_step(logic [9:0] s);
      return {s[8:0], ^(s & TAPS)};
   endfunction

   // Grid cell {col,row} that a given LFSR value maps to.
   function automatic logic [9:0] to_cell(logic [9:0] s);
      int row;
      logic [4:0] r;
      row = int'(s[9:5]);
      if (row >= 24) row = row - 8;
      r = row[4:0];
      return {s[4:0], r};
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_cand(logic [9:0] hv);
      m_cand = hv;
      cand_q.push_back(hv);
   endtask

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      m_lfsr <= reset ? 10'h2A5 : lfsr_step(m_lfsr);
   end

   // Monitor: compares every new query and every commit against the queues.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            prev_req   = 1'b0;
            prev_valid = 1'b0;
         end else begin
            got_hv = {occ_h, occ_v};
            if (occ_req && !prev_req) begin
               check("query_expected", int'(cand_q.size() > 0), 1);
               if (cand_q.size() > 0) check("candidate", got_hv, cand_q.pop_front());
               check("row_range", int'(occ_v < 5'd24), 1);
               $display("query cand=(%0d,%0d) cyc=%0d", occ_h, occ_v, cyc);
            end else if (occ_req && prev_req) begin
               check("cand_stable", got_hv, prev_hv);
            end
            if (food_valid && !prev_valid) begin
               check("commit_expected", int'(food_q.size() > 0), 1);
               if (food_q.size() > 0) begin
                  exp_food = food_q.pop_front();
                  check("food_cell", {food_h, food_v}, exp_food.hv);
                  check("commit_cycle", cyc, exp_food.at);
               end
               $display("commit food=(%0d,%0d) cyc=%0d", food_h, food_v, cyc);
            end
            prev_req   = occ_req;
            prev_valid = food_valid;
            prev_hv    = got_hv;
         end
      end
   end

   task automatic do_reset(int n);
      reset = 1'b1;
      repeat (n) begin
         @(negedge clk);
         check("rst_occ_req", occ_req, 0);
         check("rst_food_valid", food_valid, 0);
         check("rst_busy", busy, 1);
         check("rst_occ_hv", {occ_h, occ_v}, 0);
         check("rst_food_hv", {food_h, food_v}, 0);
      end
      cand_q.delete();
      food_q.delete();
      reset  = 1'b0;
      streak = 0;
      push_cand(to_cell(10'h2A5));
   endtask

   // Answer one query after dly cycles (random if negative), optionally with ignored noise.
   task automatic serve(bit hit, int dly, bit noise);
      int n = 0;
      int d;
      while (!occ_req && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("query_arrives", occ_req, 1);
      if (!occ_req) return;
      d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      repeat (d) begin
         if (noise) begin
            eat        = 1'($urandom_range(0, 1));
            frame_tick = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      eat        = 1'b0;
      frame_tick = 1'b0;
      occ_ack    = 1'b1;
      occ_hit    = hit;
      streak     = hit ? streak + 1 : 0;
      capped     = 1'b0;
`ifdef FOOD_RETRY_CAP_EN
      capped     = hit && (streak == 32);
`endif
      if (hit && !capped) push_cand(to_cell(lfsr_step(m_lfsr)));
      @(negedge clk);
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      check("req_drop_after_ack", occ_req, 0);
`ifdef FOOD_RETRY_CAP_EN
      if (capped) begin
         check("cap_food_fail", food_fail, 1);
         check("cap_busy", busy, 0);
         check("cap_food_valid", food_valid, 0);
      end
`endif
   endtask

   // Wait n cycles in ARM (optionally with stray acks), then tick and expect the commit.
   task automatic arm(int n, bit stray);
      repeat (n) begin
         if (stray) begin
            occ_ack = 1'($urandom_range(0, 1));
            occ_hit = 1'b1;
         end
         @(negedge clk);
      end
      occ_ack    = 1'b0;
      occ_hit    = 1'b0;
      frame_tick = 1'b1;
      food_q.push_back('{m_cand, cyc + 1});
      @(negedge clk);
      frame_tick = 1'b0;
      check("food_visible", food_valid, 1);
      check("busy_commit", busy, 1);
      @(negedge clk);
      check("busy_idle", busy, 0);
   endtask

   task automatic idle_noise(int n);
      repeat (n) begin
         frame_tick = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      frame_tick = 1'b0;
      check("idle_keeps_food", food_valid, 1);
   endtask

   task automatic do_eat(bit with_tick);
      eat        = 1'b1;
      frame_tick = with_tick;
      streak     = 0;
      push_cand(to_cell(lfsr_step(m_lfsr)));
      @(negedge clk);
      eat        = 1'b0;
      frame_tick = 1'b0;
      check("eat_clears_valid", food_valid, 0);
      check("eat_busy", busy, 1);
`ifdef FOOD_RETRY_CAP_EN
      check("eat_clears_fail", food_fail, 0);
`endif
      @(negedge clk);
      check("eat_new_query", occ_req, 1);
   endtask

   initial begin
      do_reset(2);
      serve(1'b0, 0, 1'b0);
      arm(9, 1'b0);
      check("first_food", {food_h, food_v}, {5'd5, 5'd21});

      idle_noise(3);
      do_eat(1'b0);
      repeat (3) serve(1'b1, -1, 1'b1);
      serve(1'b0, -1, 1'b1);
      arm(int'($urandom_range(0, 6)), 1'b1);

      idle_noise(2);
      do_eat(1'b1);
      serve(1'b0, -1, 1'b0);
      arm(2, 1'b0);

      for (int i = 0; i < 20; i++) begin
         idle_noise(int'($urandom_range(0, 4)));
         do_eat(1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) serve(1'b1, -1, 1'b1);
         serve(1'b0, -1, 1'b1);
         arm(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      end

      // Reset mid-query, then a late ack that must be ignored.
      do_eat(1'b0);
      do_reset(1);
      occ_ack = 1'b1;
      occ_hit = 1'b1;
      @(negedge clk);
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      check("restart_cand", {occ_h, occ_v}, {5'd5, 5'd21});
      serve(1'b0, -1, 1'b0);
      arm(3, 1'b0);

      do_eat(1'b0);
`ifdef FOOD_RETRY_CAP_EN
      repeat (32) serve(1'b1, 0, 1'b0);
      do_eat(1'b0);
`else
      repeat (40) serve(1'b1, 0, 1'b0);
`endif
      serve(1'b0, -1, 1'b0);
      arm(1, 1'b0);

      repeat (4) @(negedge clk);
      check("cand_q_drained", cand_q.size(), 0);
      check("food_q_drained", food_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
